// File: rtl/act_pwl_pkg.sv
// Shared widths, mode encoding and helpers for the PWL activation pipeline.
package act_pwl_pkg;

  localparam int unsigned BusNum        = 8;
  localparam int unsigned Fdw           = 8;
  localparam int unsigned ScalaPosWidth = 5;
  localparam int unsigned SegBits       = 4;
  localparam int unsigned CoefWidth     = 8;
  localparam int unsigned SegNum        = 2 ** SegBits;
  localparam int unsigned ProdWidth     = Fdw + CoefWidth;
  localparam int unsigned AccWidth      = ProdWidth + 1;

  localparam logic signed [AccWidth-1:0] SatMax = AccWidth'((1 << (Fdw - 1)) - 1);
  localparam logic signed [AccWidth-1:0] SatMin = AccWidth'(-(1 << (Fdw - 1)));

  typedef enum logic [1:0] {
    ActIdent = 2'd0,
    ActRelu  = 2'd1,
    ActPwl   = 2'd2,
    ActRsvd  = 2'd3
  } act_mode_e;

  function automatic logic signed [Fdw-1:0] sat_fdw(input logic signed [AccWidth-1:0] v);
    if (v > SatMax) begin
      return SatMax[Fdw-1:0];
    end else if (v < SatMin) begin
      return SatMin[Fdw-1:0];
    end
    return v[Fdw-1:0];
  endfunction

  // Offset-binary top bits: segment 0 holds the most negative inputs.
  function automatic logic [SegBits-1:0] seg_idx(input logic [Fdw-1:0] x);
    return {~x[Fdw-1], x[Fdw-2 -: SegBits-1]};
  endfunction

endpackage

// File: rtl/activation_pwl_lane.sv
// One lane of the activation datapath: S2 multiply and S3 round/shift/bias/saturate.
module activation_pwl_lane
  import act_pwl_pkg::*;
(
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            adv_i,
  input  logic signed [Fdw-1:0]           x_i,
  input  logic signed [CoefWidth-1:0]     slope_i,
  input  logic signed [Fdw-1:0]           bias_i,
  input  act_mode_e                       mode_i,
  input  logic        [ScalaPosWidth-1:0] sp_i,
  output logic signed [Fdw-1:0]           y_o
);

  logic signed [ProdWidth-1:0]     prod_d, prod_q;
  logic signed [AccWidth-1:0]      bias_q;
  logic signed [Fdw-1:0]           x_q;
  act_mode_e                       mode_q;
  logic        [ScalaPosWidth-1:0] sp_q;
  logic signed [Fdw-1:0]           y_d, y_q;

  logic signed [AccWidth-1:0] rnd, sum, shifted, pwl;

  assign prod_d = ProdWidth'(slope_i) * ProdWidth'(x_i);

  always_comb begin
    rnd     = '0;
    if (sp_q != '0) begin
      rnd = AccWidth'(1) << (sp_q - ScalaPosWidth'(1));
    end
    sum     = AccWidth'(prod_q) + rnd;
    shifted = sum >>> sp_q;
    pwl     = shifted + bias_q;
    case (mode_q)
      ActRelu: y_d = x_q[Fdw-1] ? '0 : x_q;
      ActPwl:  y_d = sat_fdw(pwl);
      default: y_d = x_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod_q <= '0;
      bias_q <= '0;
      x_q    <= '0;
      mode_q <= ActIdent;
      sp_q   <= '0;
      y_q    <= '0;
    end else if (adv_i) begin
      prod_q <= prod_d;
      bias_q <= AccWidth'(bias_i);
      x_q    <= x_i;
      mode_q <= mode_i;
      sp_q   <= sp_i;
      y_q    <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/activation_pwl_pipe.sv
// Three-stage activation unit (identity / ReLU / table-driven PWL) with lockstep stall.
module activation_pwl_pipe
  import act_pwl_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               cfg_mode_i,
  input  logic [ScalaPosWidth-1:0] cfg_scala_pos_i,
  input  logic                     tbl_wr_en_i,
  input  logic [SegBits-1:0]       tbl_wr_addr_i,
  input  logic [CoefWidth-1:0]     tbl_wr_slope_i,
  input  logic [Fdw-1:0]           tbl_wr_bias_i,
  input  logic [BusNum*Fdw-1:0]    in_data_i,
  input  logic [BusNum-1:0]        in_lane_vld_i,
  input  logic                     in_vld_i,
  output logic                     in_rdy_o,
  output logic [BusNum*Fdw-1:0]    out_data_o,
  output logic [BusNum-1:0]        out_lane_vld_o,
  output logic                     out_vld_o,
  input  logic                     out_rdy_i,
  output logic                     busy_o
);

  logic [CoefWidth-1:0] tbl_slope_q [SegNum];
  logic [Fdw-1:0]       tbl_bias_q  [SegNum];

  logic                     adv;
  logic                     s1_vld_q, s2_vld_q, out_vld_q;
  logic [BusNum-1:0]        s1_mask_q, s2_mask_q, out_mask_q;
  act_mode_e                s1_mode_q;
  logic [ScalaPosWidth-1:0] s1_sp_q;

  assign adv = !out_vld_q || out_rdy_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SegNum; s++) begin
        tbl_slope_q[s] <= '0;
        tbl_bias_q[s]  <= '0;
      end
    end else if (tbl_wr_en_i) begin
      tbl_slope_q[tbl_wr_addr_i] <= tbl_wr_slope_i;
      tbl_bias_q[tbl_wr_addr_i]  <= tbl_wr_bias_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      s1_mask_q  <= '0;
      s2_mask_q  <= '0;
      out_mask_q <= '0;
      s1_mode_q  <= ActIdent;
      s1_sp_q    <= '0;
    end else if (adv) begin
      s1_vld_q   <= in_vld_i;
      s2_vld_q   <= s1_vld_q;
      out_vld_q  <= s2_vld_q;
      s1_mask_q  <= in_lane_vld_i;
      s2_mask_q  <= s1_mask_q;
      out_mask_q <= s2_mask_q;
      s1_mode_q  <= act_mode_e'(cfg_mode_i);
      s1_sp_q    <= cfg_scala_pos_i;
    end
  end

  for (genvar i = 0; i < BusNum; i++) begin : g_lane
    logic [SegBits-1:0]          seg;
    logic signed [Fdw-1:0]       x_q, bias_q, y;
    logic signed [CoefWidth-1:0] slope_q;

    // Table is read with the registered (pre-write) contents, so a same-cycle write is not seen.
    assign seg = seg_idx(in_data_i[i*Fdw +: Fdw]);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        x_q     <= '0;
        slope_q <= '0;
        bias_q  <= '0;
      end else if (adv) begin
        x_q     <= in_data_i[i*Fdw +: Fdw];
        slope_q <= tbl_slope_q[seg];
        bias_q  <= tbl_bias_q[seg];
      end
    end

    activation_pwl_lane u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .adv_i   (adv),
      .x_i     (x_q),
      .slope_i (slope_q),
      .bias_i  (bias_q),
      .mode_i  (s1_mode_q),
      .sp_i    (s1_sp_q),
      .y_o     (y)
    );

    assign out_data_o[i*Fdw +: Fdw] = y;
  end

  assign in_rdy_o       = adv;
  assign out_vld_o      = out_vld_q;
  assign out_lane_vld_o = out_mask_q;
  assign busy_o         = s1_vld_q | s2_vld_q | out_vld_q;

endmodule

// File: tb/tb_activation_pwl_pipe.sv
// Directed self-checking bench for activation_pwl_pipe.
module tb_activation_pwl_pipe;
  import act_pwl_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [1:0]               cfg_mode;
  logic [ScalaPosWidth-1:0] cfg_scala_pos;
  logic                     tbl_wr_en;
  logic [SegBits-1:0]       tbl_wr_addr;
  logic [CoefWidth-1:0]     tbl_wr_slope;
  logic [Fdw-1:0]           tbl_wr_bias;
  logic [BusNum*Fdw-1:0]    in_data;
  logic [BusNum-1:0]        in_lane_vld;
  logic                     in_vld;
  logic                     in_rdy;
  logic [BusNum*Fdw-1:0]    out_data;
  logic [BusNum-1:0]        out_lane_vld;
  logic                     out_vld;
  logic                     out_rdy;
  logic                     busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  activation_pwl_pipe dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cfg_mode_i      (cfg_mode),
    .cfg_scala_pos_i (cfg_scala_pos),
    .tbl_wr_en_i     (tbl_wr_en),
    .tbl_wr_addr_i   (tbl_wr_addr),
    .tbl_wr_slope_i  (tbl_wr_slope),
    .tbl_wr_bias_i   (tbl_wr_bias),
    .in_data_i       (in_data),
    .in_lane_vld_i   (in_lane_vld),
    .in_vld_i        (in_vld),
    .in_rdy_o        (in_rdy),
    .out_data_o      (out_data),
    .out_lane_vld_o  (out_lane_vld),
    .out_vld_o       (out_vld),
    .out_rdy_i       (out_rdy),
    .busy_o          (busy)
  );

  function automatic logic [BusNum*Fdw-1:0] pack(input int v[BusNum]);
    logic [BusNum*Fdw-1:0] r;
    for (int i = 0; i < BusNum; i++) r[i*Fdw +: Fdw] = v[i][Fdw-1:0];
    return r;
  endfunction

  task automatic wr_tbl(input int addr, input int slope, input int bias);
    tbl_wr_en    = 1'b1;
    tbl_wr_addr  = addr[SegBits-1:0];
    tbl_wr_slope = slope[CoefWidth-1:0];
    tbl_wr_bias  = bias[Fdw-1:0];
    @(negedge clk);
    tbl_wr_en = 1'b0;
  endtask

  task automatic send(input logic [BusNum*Fdw-1:0] d, input logic [BusNum-1:0] m);
    in_data     = d;
    in_lane_vld = m;
    in_vld      = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_vld) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; out_rdy = 1'b1; in_vld = 1'b0; tbl_wr_en = 1'b0;
    cfg_mode = 2'd0; cfg_scala_pos = '0; in_data = '0; in_lane_vld = '0;
    tbl_wr_addr = '0; tbl_wr_slope = '0; tbl_wr_bias = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_checks++; if (out_lane_vld !== '0) begin n_fail++; $display("FAIL reset_lane_vld got %h want 0", out_lane_vld); end
  endtask

  task automatic test_identity();
    int xs[BusNum] = '{-5, 0, 7, 127, -5, 0, 7, 127};
    bit ok;
    for (int m = 0; m < 2; m++) begin
      cfg_mode = (m == 0) ? 2'd0 : 2'd3;
      cfg_scala_pos = 5'd5;
      n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL ident_in_rdy0 got %b want 1", in_rdy); end
      send(pack(xs), 8'hFF);
      n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL ident_lat1 got %b want 0", out_vld); end
      n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL ident_in_rdy1 got %b want 1", in_rdy); end
      @(negedge clk);
      n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL ident_lat2 got %b want 0", out_vld); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ident_busy got %b want 1", busy); end
      @(negedge clk);
      n_checks++; if (out_vld !== 1'b1) begin n_fail++; $display("FAIL ident_lat3 got %b want 1", out_vld); end
      n_checks++; if (out_data !== pack(xs)) begin n_fail++; $display("FAIL ident_data mode %0d got %h want %h", m, out_data, pack(xs)); end
      n_checks++; if (out_lane_vld !== 8'hFF) begin n_fail++; $display("FAIL ident_mask got %h want ff", out_lane_vld); end
      n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL ident_in_rdy3 got %b want 1", in_rdy); end
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ident_idle got %b want 0", busy); end
    end
    ok = 1'b1;
  endtask

  task automatic test_relu();
    int xs[BusNum] = '{-128, -1, 0, 1, 127, -128, -1, 1};
    int ys[BusNum] = '{0, 0, 0, 1, 127, 0, 0, 1};
    bit ok;
    cfg_mode = 2'd1;
    send(pack(xs), 8'hA5);
    wait_out(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL relu_timeout got none want beat"); end
    else if (out_data !== pack(ys)) begin n_fail++; $display("FAIL relu_data got %h want %h", out_data, pack(ys)); end
    n_checks++; if (out_lane_vld !== 8'hA5) begin n_fail++; $display("FAIL relu_mask got %h want a5", out_lane_vld); end
    @(negedge clk);
  endtask

  task automatic test_pwl();
    int xa[BusNum] = '{-128, -5, 0, 3, 127, -1, 50, -77};
    int xb[BusNum] = '{127, 3, -3, 0, 0, 0, 0, 0};
    int yb[BusNum] = '{127, 2, -96, 0, 0, 0, 0, 0};
    int yc[BusNum] = '{-128, 3, -128, 0, 0, 0, 0, 0};
    bit ok;
    cfg_mode = 2'd2;
    for (int s = 0; s < SegNum; s++) wr_tbl(s, 64, 0);
    cfg_scala_pos = 5'd6;
    send(pack(xa), 8'hFF);
    wait_out(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL pwl_unity_timeout got none want beat"); end
    else if (out_data !== pack(xa)) begin n_fail++; $display("FAIL pwl_unity got %h want %h", out_data, pack(xa)); end
    @(negedge clk);
    wr_tbl(15, 127, 100);
    wr_tbl(8, 1, 0);
    cfg_scala_pos = 5'd1;
    send(pack(xb), 8'hFF);
    wait_out(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL pwl_round_timeout got none want beat"); end
    else if (out_data !== pack(yb)) begin n_fail++; $display("FAIL pwl_round_sat got %h want %h", out_data, pack(yb)); end
    @(negedge clk);
    wr_tbl(15, -128, 0);
    cfg_scala_pos = 5'd0;
    send(pack(xb), 8'hFF);
    wait_out(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL pwl_negsat_timeout got none want beat"); end
    else if (out_data !== pack(yc)) begin n_fail++; $display("FAIL pwl_negsat got %h want %h", out_data, pack(yc)); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, cyc = 0;
    bit hold = 1'b0;
    logic [BusNum*Fdw-1:0] held_data;
    logic [BusNum-1:0]     held_mask;
    int v[BusNum];
    cfg_mode = 2'd0;
    while (got < 10 && cyc < 200) begin
      @(negedge clk);
      if (hold) begin
        n_checks++;
        if (out_vld !== 1'b1 || out_data !== held_data || out_lane_vld !== held_mask) begin
          n_fail++;
          $display("FAIL bp_stable got %b/%h want 1/%h", out_vld, out_data, held_data);
        end
      end
      out_rdy = (cyc % 3 == 0);
      in_vld  = (sent < 10);
      for (int i = 0; i < BusNum; i++) v[i] = sent * 8 + i - 40;
      in_data     = pack(v);
      in_lane_vld = 8'(sent * 13 + 1);
      #1;
      if (out_vld && out_rdy) begin
        for (int i = 0; i < BusNum; i++) v[i] = got * 8 + i - 40;
        n_checks++;
        if (out_data !== pack(v) || out_lane_vld !== 8'(got * 13 + 1)) begin
          n_fail++;
          $display("FAIL bp_beat%0d got %h want %h", got, out_data, pack(v));
        end
        got++;
      end
      hold      = out_vld && !out_rdy;
      held_data = out_data;
      held_mask = out_lane_vld;
      if (in_vld && in_rdy) sent++;
      cyc++;
    end
    n_checks++;
    if (got != 10) begin n_fail++; $display("FAIL bp_count got %0d want 10", got); end
    @(negedge clk);
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", busy); end
  endtask

  task automatic test_mode_switch();
    int v[BusNum];
    int e[BusNum];
    out_rdy = 1'b1;
    for (int s = 0; s < SegNum; s++) wr_tbl(s, 64, 0);
    cfg_scala_pos = 5'd6;
    for (int c = 0; c <= 10; c++) begin
      if (c >= 3) begin
        int k = c - 3;
        for (int i = 0; i < BusNum; i++) begin
          if (k < 4) e[i] = (i - 4 + k < 0) ? 0 : i - 4 + k;
          else if (k == 4) e[i] = i + k;
          else e[i] = 10 - (i + k);
        end
        n_checks++;
        if (out_vld !== 1'b1 || out_data !== pack(e) || out_lane_vld !== 8'(k * 37 + 1)) begin
          n_fail++;
          $display("FAIL ms_beat%0d got %b/%h want 1/%h", k, out_vld, out_data, pack(e));
        end
      end
      tbl_wr_en = 1'b0;
      if (c < 8) begin
        for (int i = 0; i < BusNum; i++) v[i] = (c < 4) ? i - 4 + c : i + c;
        cfg_mode    = (c < 4) ? 2'd1 : 2'd2;
        in_data     = pack(v);
        in_lane_vld = 8'(c * 37 + 1);
        in_vld      = 1'b1;
      end else begin
        in_vld        = 1'b0;
        cfg_mode      = 2'd0;
        cfg_scala_pos = 5'd0;
      end
      if (c == 4) begin
        tbl_wr_en    = 1'b1;
        tbl_wr_addr  = 4'd8;
        tbl_wr_slope = 8'hC0;
        tbl_wr_bias  = 8'd10;
      end
      @(negedge clk);
    end
    in_vld = 1'b0;
    tbl_wr_en = 1'b0;
  endtask

  task automatic test_reset_flight();
    int v[BusNum] = '{0, 1, 2, 3, 4, 5, 6, 7};
    int z[BusNum] = '{0, 0, 0, 0, 0, 0, 0, 0};
    bit ok;
    cfg_mode = 2'd2; cfg_scala_pos = 5'd0; out_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data = pack(v); in_lane_vld = 8'hFF; in_vld = 1'b1;
      @(negedge clk);
    end
    in_vld = 1'b0;
    n_checks++; if (out_vld !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rf_inflight got %b/%b want 1/1", out_vld, busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rf_out_vld got %b want 0", out_vld); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rf_busy got %b want 0", busy); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rf_out_data got %h want 0", out_data); end
    send(pack(v), 8'h3C);
    wait_out(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rf_timeout got none want beat"); end
    else if (out_data !== pack(z) || out_lane_vld !== 8'h3C) begin
      n_fail++;
      $display("FAIL rf_table_clear got %h/%h want %h/3c", out_data, out_lane_vld, pack(z));
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_relu();
    test_pwl();
    test_back_to_back();
    test_mode_switch();
    test_reset_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got hang want finish");
    $fatal(1, "timeout");
  end

endmodule
